// File: rtl/mem_access_ctrl.sv
// Multicycle sequencer for the PC register and memory-address mux: shares one
// memory port between instruction fetch and load/store data via req/ack.
module mem_access_ctrl #(
  parameter int REG_LEN = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_ack,
  input  logic       dec_load,
  input  logic       dec_store,
  input  logic       dec_jump,
  input  logic       dec_replay,
  input  logic       dec_halt,
  output logic [1:0] pc_sel,
  output logic       mem_sel,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_load,
  output logic       rd_load,
  output logic       exec_en,
  output logic       halted,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DATA,
    S_HALT,
    S_ERROR
  } state_t;

  localparam logic [1:0] PC_ALU  = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_DEC  = 2'b10;
  localparam logic [1:0] PC_HOLD = 2'b11;

  localparam bit             TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_EN ? TIMEOUT - 1 : 0);

  // The wait counter must be able to reach TIMEOUT-1 without wrapping.
  if (REG_LEN < 1 || TIMEOUT < 0 || (TIMEOUT >> CNT_W) != 0) begin : g_bad_params
    $error("mem_access_ctrl: invalid REG_LEN/TIMEOUT/CNT_W combination");
  end

  state_t           state, state_nx;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
  logic             store_q, store_nx;
  logic             expired;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      store_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      store_q  <= store_nx;
    end
  end

  // Last permitted wait cycle; an ack in this same cycle still completes.
  assign expired = TIMEOUT_EN && (wait_cnt == LAST_WAIT);

  // NOTE: every output and next-state signal gets a default before the case,
  // so no path through this block can infer a latch.
  always_comb begin
    state_nx = state;
    store_nx = store_q;
    pc_sel   = PC_HOLD;
    mem_sel  = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    ir_load  = 1'b0;
    rd_load  = 1'b0;
    exec_en  = 1'b0;
    halted   = 1'b0;
    err      = 1'b0;

    case (state)
      S_IDLE: state_nx = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load  = 1'b1;
          pc_sel   = PC_INC;
          state_nx = S_EXEC;
        end else if (expired) begin
          state_nx = S_ERROR;
        end
      end

      S_EXEC: begin
        exec_en = 1'b1;
        if (dec_halt) begin
          state_nx = S_HALT;
        end else if (dec_load || dec_store) begin
          store_nx = dec_store;
          state_nx = S_DATA;
        end else if (dec_jump) begin
          pc_sel   = PC_ALU;
          state_nx = S_FETCH;
        end else if (dec_replay) begin
          pc_sel   = PC_DEC;
          state_nx = S_FETCH;
        end else begin
          state_nx = S_FETCH;
        end
      end

      S_DATA: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = store_q;
        if (mem_ack) begin
          rd_load  = !store_q;
          state_nx = S_FETCH;
        end else if (expired) begin
          state_nx = S_ERROR;
        end
      end

      S_HALT:  halted = 1'b1;

      S_ERROR: err = 1'b1;

      default: state_nx = S_IDLE;
    endcase
  end

  // Wait cycles are only counted while a request is outstanding in one state.
  always_comb begin
    if (state_nx != state || mem_ack) begin
      wait_cnt_nx = '0;
    end else if (state == S_FETCH || state == S_DATA) begin
      wait_cnt_nx = wait_cnt + 1'b1;
    end else begin
      wait_cnt_nx = '0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Cycle-accurate scoreboard bench for mem_access_ctrl (TIMEOUT=4): each
// scenario queues expected output vectors and compares them at the negedge.
module tb_mem_access_ctrl;

  logic       clk;
  logic       rst;
  logic       mem_ack, dec_load, dec_store, dec_jump, dec_replay, dec_halt;
  logic [1:0] pc_sel;
  logic       mem_sel, mem_req, mem_we, ir_load, rd_load, exec_en, halted, err;

  mem_access_ctrl #(.REG_LEN(32), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_ack   (mem_ack),
    .dec_load  (dec_load),
    .dec_store (dec_store),
    .dec_jump  (dec_jump),
    .dec_replay(dec_replay),
    .dec_halt  (dec_halt),
    .pc_sel    (pc_sel),
    .mem_sel   (mem_sel),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .ir_load   (ir_load),
    .rd_load   (rd_load),
    .exec_en   (exec_en),
    .halted    (halted),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_sel, mem_sel, mem_req, mem_we, ir_load, rd_load, exec_en, halted, err}
  wire [9:0] obs = {pc_sel, mem_sel, mem_req, mem_we, ir_load, rd_load, exec_en, halted, err};

  localparam logic [9:0] DEF      = 10'b11_0000_0000;
  localparam logic [9:0] F_ACK    = 10'b01_0101_0000;
  localparam logic [9:0] F_WAIT   = 10'b11_0100_0000;
  localparam logic [9:0] EX_HOLD  = 10'b11_0000_0100;
  localparam logic [9:0] EX_JMP   = 10'b00_0000_0100;
  localparam logic [9:0] EX_REP   = 10'b10_0000_0100;
  localparam logic [9:0] D_LD     = 10'b11_1100_0000;
  localparam logic [9:0] D_LD_ACK = 10'b11_1100_1000;
  localparam logic [9:0] D_ST     = 10'b11_1110_0000;
  localparam logic [9:0] HLT      = 10'b11_0000_0010;
  localparam logic [9:0] ERR      = 10'b11_0000_0001;

  typedef struct {
    bit         rst_v, ack, ld, st, jmp, rep, hlt;
    logic [9:0] exp;
  } vec_t;

  logic [9:0] exp_q[$];
  logic [9:0] exp_v;
  int         n_vec = 0;
  int         n_err = 0;

  function automatic vec_t mk(bit rst_v, bit ack, bit ld, bit st, bit jmp, bit rep,
                              bit hlt, logic [9:0] exp);
    vec_t v;
    v.rst_v = rst_v; v.ack = ack; v.ld = ld; v.st = st;
    v.jmp = jmp; v.rep = rep; v.hlt = hlt; v.exp = exp;
    return v;
  endfunction

  // Applies one cycle of stimulus just after the edge and queues its expectation.
  task automatic drive(input vec_t v);
    @(posedge clk);
    #1;
    rst        = v.rst_v;
    mem_ack    = v.ack;
    dec_load   = v.ld;
    dec_store  = v.st;
    dec_jump   = v.jmp;
    dec_replay = v.rep;
    dec_halt   = v.hlt;
    exp_q.push_back(v.exp);
  endtask

  task automatic test_reset();
    vec_t v[$];
    for (int i = 0; i < 3; i++) v.push_back(mk(0, 1, 1, 0, 1, 0, 1, DEF));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL reset[%0d]: got %b, expected %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_fetch_exec();
    vec_t v[$];
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, DEF));
    for (int i = 0; i < 3; i++) begin
      v.push_back(mk(1, 1, 0, 0, 0, 0, 0, F_ACK));
      v.push_back(mk(1, 1, 0, 0, 0, 0, 0, EX_HOLD));
    end
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL fetch_exec[%0d]: got %b, expected %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_store_jump();
    vec_t v[$];
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, F_ACK));
    v.push_back(mk(1, 1, 0, 1, 1, 0, 0, EX_HOLD));
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0, D_ST));
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, D_ST));
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, F_ACK));
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, EX_HOLD));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL store_jump[%0d]: got %b, expected %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_load_wait();
    vec_t v[$];
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, F_ACK));
    v.push_back(mk(1, 1, 1, 0, 0, 1, 0, EX_HOLD));
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0, D_LD));
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0, D_LD));
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, D_LD_ACK));
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, F_ACK));
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, EX_HOLD));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL load_wait[%0d]: got %b, expected %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_jump_replay();
    vec_t v[$];
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, F_ACK));
    v.push_back(mk(1, 1, 0, 0, 1, 0, 0, EX_JMP));
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, F_ACK));
    v.push_back(mk(1, 1, 0, 0, 0, 1, 0, EX_REP));
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, F_ACK));
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, EX_HOLD));
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, F_ACK));
    v.push_back(mk(1, 1, 0, 0, 1, 1, 0, EX_JMP));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL jump_replay[%0d]: got %b, expected %b", i, obs, exp_v);
      end
    end
  endtask

  // Ack on the last permitted wait cycle must complete normally.
  task automatic test_timeout_boundary();
    vec_t v[$];
    for (int i = 0; i < 3; i++) v.push_back(mk(1, 0, 0, 0, 0, 0, 0, F_WAIT));
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, F_ACK));
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0, EX_HOLD));
    for (int i = 0; i < 3; i++) v.push_back(mk(1, 0, 0, 0, 0, 0, 0, F_WAIT));
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, F_ACK));
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, EX_HOLD));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL timeout_boundary[%0d]: got %b, expected %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_timeout_error();
    vec_t v[$];
    for (int i = 0; i < 4; i++) v.push_back(mk(1, 0, 0, 0, 0, 0, 0, F_WAIT));
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, ERR));
    v.push_back(mk(1, 1, 1, 0, 1, 0, 0, ERR));
    v.push_back(mk(1, 0, 0, 0, 0, 0, 1, ERR));
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, ERR));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL timeout_error[%0d]: got %b, expected %b", i, obs, exp_v);
      end
    end
  endtask

  // Reset out of ERROR, reset mid-DATA, then halt until the next reset.
  task automatic test_reset_mid_data_halt();
    vec_t v[$];
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, ERR));
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, DEF));
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, F_ACK));
    v.push_back(mk(1, 1, 1, 0, 0, 0, 0, EX_HOLD));
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0, D_LD));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, D_LD));
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, DEF));
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, F_ACK));
    v.push_back(mk(1, 1, 1, 0, 1, 0, 1, EX_HOLD));
    for (int i = 0; i < 3; i++) v.push_back(mk(1, 1, 1, 1, 1, 1, 0, HLT));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 0, HLT));
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, DEF));
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0, F_ACK));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL reset_mid_data_halt[%0d]: got %b, expected %b", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    rst        = 1'b0;
    mem_ack    = 1'b0;
    dec_load   = 1'b0;
    dec_store  = 1'b0;
    dec_jump   = 1'b0;
    dec_replay = 1'b0;
    dec_halt   = 1'b0;

    test_reset();
    test_fetch_exec();
    test_store_jump();
    test_load_wait();
    test_jump_replay();
    test_timeout_boundary();
    test_timeout_error();
    test_reset_mid_data_halt();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multicycle sequencer for the core's PC register and memory-address mux.
- Drives pc_sel and mem_sel, and shares the single memory port between instruction fetch and load/store data access using a req/ack handshake.
- Sits between the instruction decoder and the PC/address-select datapath.
- Provides a wait-state timeout and a sticky error state.

Parameters:
- REG_LEN, 32, width of address/data path (used only for consistency; no address arithmetic inside).
- TIMEOUT, 16, maximum cycles mem_req may stay high without mem_ack before ERROR. 0 disables the timeout.
- CNT_W, 8, wait-counter width. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-low (rst==0 at posedge resets).
- mem_ack  input  1  memory completes the current transaction this cycle.
- dec_load  input  1  decoded instruction is a load (sampled in EXEC).
- dec_store  input  1  decoded instruction is a store (sampled in EXEC).
- dec_jump  input  1  jump/taken branch; next PC comes from the ALU (sampled in EXEC).
- dec_replay  input  1  re-execute the current instruction; PC steps back 4 (sampled in EXEC).
- dec_halt  input  1  halt instruction (sampled in EXEC).
- pc_sel  output  2  00 = ALU, 01 = PC+4, 10 = PC-4, 11 = hold.
- mem_sel  output  1  0 = address from PC, 1 = address from ALU.
- mem_req  output  1  memory transaction request.
- mem_we  output  1  write strobe; valid only while mem_req is high.
- ir_load  output  1  load the instruction register.
- rd_load  output  1  write load data to the register file.
- exec_en  output  1  execute/ALU stage enable.
- halted  output  1  core is in HALT.
- err  output  1  sticky memory timeout error.

Behaviour:
- States: IDLE, FETCH, EXEC, DATA, HALT, ERROR. All outputs are decoded from the state, plus mem_ack where noted.
- Default output values in every state: pc_sel=11, mem_sel=0, all 1-bit outputs 0.
- Reset (rst==0): state goes to IDLE, wait counter clears to 0, store flag clears to 0. Reset overrides every other event, including mid-transaction. While in IDLE all outputs hold their default values.
- IDLE: unconditionally goes to FETCH on the next cycle. This gives one dead cycle after reset release.
- FETCH:
  - Drives mem_req=1, mem_sel=0, mem_we=0.
  - If mem_ack: ir_load=1 and pc_sel=01 in that same cycle, then go to EXEC. Fetch latency is 1 cycle with zero wait states.
- EXEC: exec_en=1 for exactly one cycle. Decisions use this priority order:
  - dec_halt: go to HALT; pc_sel=11.
  - dec_load or dec_store: latch dec_store into the store flag, go to DATA; pc_sel=11. dec_jump and dec_replay are ignored.
  - dec_jump: pc_sel=00, go to FETCH.
  - dec_replay: pc_sel=10, go to FETCH.
  - Otherwise: pc_sel=11, go to FETCH.
- DATA:
  - Drives mem_req=1, mem_sel=1, mem_we=store flag.
  - If mem_ack: rd_load = NOT store flag, then go to FETCH; pc_sel=11.
- HALT: halted=1, mem_req=0. Exited only by reset.
- ERROR: err=1, mem_req=0. Exited only by reset.
- Wait counter:
  - Clears on every state transition and on mem_ack.
  - Increments each FETCH/DATA cycle without mem_ack.
  - If TIMEOUT!=0 and the counter equals TIMEOUT-1 in a cycle without mem_ack, the next state is ERROR. So mem_req is high for exactly TIMEOUT cycles.
  - mem_ack in the same cycle as expiry wins: the transaction completes normally.
- mem_ack outside FETCH/DATA is ignored.
- mem_req is never high in IDLE, EXEC, HALT or ERROR.
- mem_sel=1 only in DATA.
- Throughput without waits: non-memory instruction takes 2 cycles; load/store takes 3 cycles.

Test Plan:
- Release rst after 3 cycles, mem_ack tied 1, dec_* all 0 → IDLE→FETCH→EXEC repeating. ir_load and pc_sel=01 on every FETCH cycle; exec_en on alternating cycles; mem_sel always 0.
- Load with 2 wait states (ack on 3rd DATA cycle), dec_load=1 in EXEC → mem_req high 3 cycles with mem_sel=1 and mem_we=0. rd_load=1 only on the ack cycle, then FETCH.
- Store plus simultaneous dec_jump=1 in EXEC → pc_sel=11 (jump ignored), DATA with mem_we=1, rd_load stays 0.
- dec_jump=1 then dec_replay=1 in successive EXECs → pc_sel=00, then pc_sel=10, each exactly one cycle.
- TIMEOUT=4, mem_ack held 0 in FETCH → mem_req high exactly 4 cycles, then err=1 and mem_req=0 permanently.
- Repeat with mem_ack on the 4th cycle → normal completion, no err.
- rst=0 asserted mid-DATA, then dec_halt=1 on a later EXEC → next cycle after reset: IDLE with all outputs at default. Halt then gives halted=1, mem_req=0 until the next reset.
